// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in parallel-out receiver.
package sipo_pkg;

  typedef enum logic {IDLE, SHIFT} sipo_state_t;

  // Bit counter must hold the value WIDTH itself, hence WIDTH+1 codes.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_out_reg.sv
// Output holding register: owns PO/po_valid and decides accept, hold or drop
// of a freshly completed word against the downstream ready.
module sipo_out_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             po_ready_i,
  input  logic             clr_err_i,
  output logic [WIDTH-1:0] po_o,
  output logic             po_valid_o,
  output logic             overrun_o
);

  logic [WIDTH-1:0] po_q, po_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             drop;

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    po_d    = po_q;
    valid_d = valid_q;
    drop    = 1'b0;
    if (load_i) begin
      // A completed word may enter only if the slot is free or empties this edge.
      if (valid_q && !po_ready_i) begin
        drop = 1'b1;
      end else begin
        po_d    = data_i;
        valid_d = 1'b1;
      end
    end else if (valid_q && po_ready_i) begin
      valid_d = 1'b0;
    end
    overrun_d = drop ? 1'b1 : (clr_err_i ? 1'b0 : overrun_q);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      // NOTE: the data word is reset as well because PO must read zero after reset.
      po_q      <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      po_q      <= po_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign po_o       = po_q;
  assign po_valid_o = valid_q;
  assign overrun_o  = overrun_q;

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out receiver: framing FSM, bit counter and shift register
// feeding a double-buffered output holding register.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             si_valid,
  input  logic             si,
  input  logic             si_start,
  input  logic             po_ready,
  input  logic             clr_err,
  output logic [WIDTH-1:0] PO,
  output logic             po_valid,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err
);

  localparam int CW = cnt_width(WIDTH);
  typedef logic [CW-1:0] cnt_t;

  sipo_state_t      state_q, state_d;
  cnt_t             cnt_q, cnt_d, cnt_acc;
  logic [WIDTH-1:0] shreg_q, shreg_d, shift_base, bit_vec;
  logic             frame_err_q, frame_err_d;
  logic             take, restart, word_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    take       = 1'b0;
    restart    = 1'b0;
    cnt_acc    = cnt_q;
    shift_base = shreg_q;

    unique case (state_q)
      IDLE: begin
        if (si_valid && si_start) begin
          take       = 1'b1;
          shift_base = '0;
          cnt_acc    = cnt_t'(1);
        end
      end
      SHIFT: begin
        if (si_valid) begin
          take = 1'b1;
          if (si_start) begin
            // Restart: the partial frame is thrown away and this bit becomes bit 0.
            restart    = 1'b1;
            shift_base = '0;
            cnt_acc    = cnt_t'(1);
          end else begin
            cnt_acc = cnt_q + cnt_t'(1);
          end
        end
      end
      default: ;
    endcase

    bit_vec = '0;
    if (MSB_FIRST) bit_vec[0] = si;
    else           bit_vec[WIDTH-1] = si;

    word_done = take && (cnt_acc == cnt_t'(WIDTH));

    if (take) begin
      shreg_d = MSB_FIRST ? ((shift_base << 1) | bit_vec)
                          : ((shift_base >> 1) | bit_vec);
      if (word_done) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        state_d = SHIFT;
        cnt_d   = cnt_acc;
      end
    end

    frame_err_d = restart ? 1'b1 : (clr_err ? 1'b0 : frame_err_q);
  end

  always_comb begin
    busy      = (state_q == SHIFT);
    frame_err = frame_err_q;
  end

  // The assembled word including the final bit is shreg_d at the completing edge.
  sipo_out_reg #(
    .WIDTH(WIDTH)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load_i    (word_done),
    .data_i    (shreg_d),
    .po_ready_i(po_ready),
    .clr_err_i (clr_err),
    .po_o      (PO),
    .po_valid_o(po_valid),
    .overrun_o (overrun)
  );

endmodule

// File: tb/tb_sipo_deserializer.sv
// Scoreboard bench: three builds (W4 MSB-first, W4 LSB-first, W1) share one
// stimulus stream; a frame-level model predicts words, a monitor checks them.
module tb_sipo_deserializer;

  logic clk = 1'b0;
  logic rst, si_valid, si, si_start, po_ready, clr_err;

  logic [3:0] po_m4, po_l4;
  logic [0:0] po_m1;
  logic       v_m4, v_l4, v_m1, b_m4, b_l4, b_m1;
  logic       ov_m4, ov_l4, ov_m1, fe_m4, fe_l4, fe_m1;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_m4 (
    .clk(clk), .rst(rst), .si_valid(si_valid), .si(si), .si_start(si_start),
    .po_ready(po_ready), .clr_err(clr_err), .PO(po_m4), .po_valid(v_m4),
    .busy(b_m4), .overrun(ov_m4), .frame_err(fe_m4));

  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_l4 (
    .clk(clk), .rst(rst), .si_valid(si_valid), .si(si), .si_start(si_start),
    .po_ready(po_ready), .clr_err(clr_err), .PO(po_l4), .po_valid(v_l4),
    .busy(b_l4), .overrun(ov_l4), .frame_err(fe_l4));

  sipo_deserializer #(.WIDTH(1), .MSB_FIRST(1'b1)) u_m1 (
    .clk(clk), .rst(rst), .si_valid(si_valid), .si(si), .si_start(si_start),
    .po_ready(po_ready), .clr_err(clr_err), .PO(po_m1), .po_valid(v_m1),
    .busy(b_m1), .overrun(ov_m1), .frame_err(fe_m1));

  logic [2:0] dv, db, dov, dfe;
  logic [3:0] dpo [3];
  assign dv  = {v_m1, v_l4, v_m4};
  assign db  = {b_m1, b_l4, b_m4};
  assign dov = {ov_m1, ov_l4, ov_m4};
  assign dfe = {fe_m1, fe_l4, fe_m4};
  assign dpo[0] = po_m4;
  assign dpo[1] = po_l4;
  assign dpo[2] = {3'b000, po_m1};

  // Reference model: frame progress as "bits collected so far" plus the
  // arrival-ordered bit value; output slot occupancy and sticky flags.
  int mw   [3] = '{4, 4, 1};
  bit mmsb [3] = '{1'b1, 1'b0, 1'b1};
  int m_cnt[3], m_acc[3];
  bit m_valid[3], m_ov[3], m_fe[3];
  bit m_rst;
  int q0[$], q1[$], q2[$];

  int n_checks = 0;
  int n_err    = 0;

  bit prev_v [3];
  int prev_po[3];

  task automatic check(input string name, input int k, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[dut%0d] at %0t: got %0d expected %0d", name, k, $time, act, exp);
    end
  endtask

  task automatic push(input int k, input int w);
    case (k)
      0: q0.push_back(w);
      1: q1.push_back(w);
      default: q2.push_back(w);
    endcase
  endtask

  task automatic pop(input int k, output int w, output bit ok);
    ok = 1'b0;
    w  = 0;
    case (k)
      0: if (q0.size() > 0) begin w = q0.pop_front(); ok = 1'b1; end
      1: if (q1.size() > 0) begin w = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin w = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  function automatic int form_word(input int k, input int acc);
    int w = 0;
    if (mmsb[k]) return acc;
    // First-arriving bit lands in bit 0.
    for (int i = 0; i < mw[k]; i++)
      if (((acc >> (mw[k] - 1 - i)) & 1) != 0) w |= (1 << i);
    return w;
  endfunction

  task automatic model_edge();
    m_rst = rst;
    for (int k = 0; k < 3; k++) begin
      bit done, ov_ev, fe_ev;
      int w;
      if (rst) begin
        m_cnt[k] = 0; m_acc[k] = 0;
        m_valid[k] = 1'b0; m_ov[k] = 1'b0; m_fe[k] = 1'b0;
        case (k)
          0: q0.delete();
          1: q1.delete();
          default: q2.delete();
        endcase
      end else begin
        done = 1'b0; ov_ev = 1'b0; fe_ev = 1'b0; w = 0;
        if (si_valid && si_start) begin
          if (m_cnt[k] > 0) fe_ev = 1'b1;
          m_acc[k] = int'(si);
          m_cnt[k] = 1;
        end else if (si_valid && m_cnt[k] > 0) begin
          m_acc[k] = m_acc[k] * 2 + int'(si);
          m_cnt[k]++;
        end
        if (m_cnt[k] == mw[k]) begin
          done = 1'b1;
          w = form_word(k, m_acc[k]);
          m_cnt[k] = 0;
        end
        if (done) begin
          if (m_valid[k] && !po_ready) ov_ev = 1'b1;
          else begin
            push(k, w);
            m_valid[k] = 1'b1;
          end
        end else if (m_valid[k] && po_ready) begin
          m_valid[k] = 1'b0;
        end
        m_ov[k] = ov_ev ? 1'b1 : (clr_err ? 1'b0 : m_ov[k]);
        m_fe[k] = fe_ev ? 1'b1 : (clr_err ? 1'b0 : m_fe[k]);
      end
    end
  endtask

  // Apply one cycle of inputs, predict the effect of the coming edge, advance.
  task automatic cyc(input bit r, input bit v, input bit b, input bit st,
                     input bit rdy, input bit clr);
    rst = r; si_valid = v; si = b; si_start = st; po_ready = rdy; clr_err = clr;
    model_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  task automatic frame(input int val, input int n, input bit rdy,
                       input int gap_max, input bit last_rdy);
    for (int i = n - 1; i >= 0; i--) begin
      if (gap_max > 0 && i != n - 1) idle(int'($urandom_range(1, gap_max)), rdy);
      cyc(1'b0, 1'b1, ((val >> i) & 1) != 0, i == n - 1, (i == 0) ? last_rdy : rdy, 1'b0);
    end
  endtask

  // Monitor: checks flags every cycle and pops the scoreboard on each transfer.
  initial begin
    int  w;
    bit  ok;
    for (int k = 0; k < 3; k++) begin prev_v[k] = 1'b0; prev_po[k] = 0; end
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        if (!rst && prev_v[k] && po_ready) begin
          pop(k, w, ok);
          check("word_expected", k, int'(ok), 1);
          if (ok) check("po_word", k, prev_po[k], w);
        end
        check("po_valid", k, int'(dv[k]), int'(m_valid[k]));
        check("busy", k, int'(db[k]), int'(m_cnt[k] > 0));
        check("overrun", k, int'(dov[k]), int'(m_ov[k]));
        check("frame_err", k, int'(dfe[k]), int'(m_fe[k]));
        if (m_rst) check("po_after_rst", k, int'(dpo[k]), 0);
        prev_v[k]  = dv[k];
        prev_po[k] = int'(dpo[k]);
      end
    end
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_cnt[k] = 0; m_acc[k] = 0; m_valid[k] = 0; m_ov[k] = 0; m_fe[k] = 0;
    end
    m_rst = 1'b0;

    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Basic frame 1011 with downstream always ready.
    frame(4'b1011, 4, 1'b1, 0, 1'b1);
    idle(3, 1'b1);

    // Non-start bits while idle are ignored; then a stalled frame.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    frame(4'b1011, 4, 1'b1, 3, 1'b1);
    idle(3, 1'b1);

    // Overrun: second word dropped, then drain and clear.
    frame(4'b1011, 4, 1'b0, 0, 1'b0);
    frame(4'b0110, 4, 1'b0, 0, 1'b0);
    idle(2, 1'b0);
    idle(1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);

    // Completion on the same edge as the transfer of the previous word.
    frame(4'b1011, 4, 1'b0, 0, 1'b0);
    frame(4'b0110, 4, 1'b0, 0, 1'b1);
    idle(3, 1'b1);

    // Restart mid-frame, then restart coinciding with clr_err.
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    frame(4'b0110, 4, 1'b1, 0, 1'b1);
    idle(2, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Reset mid-frame and while a word is pending, then a clean frame.
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    frame(4'b1011, 4, 1'b0, 0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(4'b1001, 4, 1'b1, 0, 1'b1);
    idle(3, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit v  = ($urandom_range(0, 9) < 7);
      bit st = v && ($urandom_range(0, 19) < 3);
      cyc($urandom_range(0, 99) == 0, v, $urandom_range(0, 1) == 1, st,
          $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
    end

    idle(10, 1'b1);
    check("drain_q", 0, q0.size(), 0);
    check("drain_q", 1, q1.size(), 0);
    check("drain_q", 2, q2.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
